// File: rtl/ox_prb_pkg.sv
// Shared probe-scheduler definitions: one-hot scheduler states, entry field widths, entry layout.
// Entry packing order, MSB to LSB: {size, source, address}.
package ox_prb_pkg;

    localparam int SIZE_W = 4;
    localparam int SRC_W  = 26;
    localparam int ADDR_W = 64;

    localparam logic [3:0] SCH_IDLE = 4'h1;
    localparam logic [3:0] SCH_REQ  = 4'h2;
    localparam logic [3:0] SCH_BUSY = 4'h4;
    localparam logic [3:0] SCH_POP  = 4'h8;

    typedef struct packed {
        logic [SIZE_W-1:0] size;
        logic [SRC_W-1:0]  source;
        logic [ADDR_W-1:0] address;
    } prb_entry_t;

endpackage

// File: rtl/n2tl_prb_sched_if.sv
// TileLink B-channel Probe handshake from OXmgr RX into the probe scheduler.
interface n2tl_prb_sched_if;
    import ox_prb_pkg::*;

    logic              b_valid;
    logic              b_ready;
    logic [SIZE_W-1:0] b_size;
    logic [SRC_W-1:0]  b_source;
    logic [ADDR_W-1:0] b_address;

    modport master (
        output b_valid, b_size, b_source, b_address,
        input  b_ready
    );

    modport slave (
        input  b_valid, b_size, b_source, b_address,
        output b_ready
    );

endinterface

// File: rtl/prb_sched_fifo.sv
// Synchronous FIFO of probe entries; head is the oldest stored entry, valid whenever !empty.
module prb_sched_fifo
    import ox_prb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  prb_entry_t               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output prb_entry_t               head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_ok, pop_ok;
    prb_entry_t    mem_q [DEPTH];

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_q == AW'(gi))) mem_q[gi] <= wr_data;
        end
    end

endmodule

// File: rtl/n2tl_prb_sched.sv
// Probe scheduler: queues B-channel Probes and dispatches them one at a time to the probe SM,
// with timeout abort and dispatch pause. Define PRB_SCHED_STATS_EN to add dispatch/timeout counters.
module n2tl_prb_sched
    import ox_prb_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    n2tl_prb_sched_if.slave        b,
    input  logic                   prb_pause,
    input  logic                   err_clr,
    output logic                   probe_req,
    input  logic                   probe_req_ack,
    input  logic                   probe_req_done,
    output logic [SIZE_W-1:0]      prb_size,
    output logic [SRC_W-1:0]       prb_source,
    output logic [ADDR_W-1:0]      prb_address,
    output logic                   prb_busy,
    output logic [$clog2(DEPTH):0] prb_q_level,
    output logic                   prb_timeout,
    output logic                   prb_err
`ifdef PRB_SCHED_STATS_EN
   ,output logic [CNT_W-1:0]       prb_disp_cnt,
    output logic [CNT_W-1:0]       prb_tmo_cnt
`endif
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    logic [3:0]       state_q, state_d;
    logic             req_q, req_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    prb_entry_t       head_q, head_d;
    logic             err_q, err_d;
    logic             init_q;
    logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
    prb_entry_t       fifo_head, fifo_wr;
    logic             dispatch, tmo, tmo_hit;

    // b_ready stays low through reset and comes up one cycle after it drops.
    assign b.b_ready = ~fifo_full & init_q;
    assign fifo_push = b.b_valid & b.b_ready;
    assign fifo_wr   = '{size: b.b_size, source: b.b_source, address: b.b_address};

    prb_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (fifo_wr),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (prb_q_level),
        .head    (fifo_head)
    );

    assign tmo_hit = (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        timer_d  = timer_q;
        head_d   = head_q;
        fifo_pop = 1'b0;
        dispatch = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            SCH_IDLE: begin
                if (!fifo_empty && !prb_pause) begin
                    state_d  = SCH_REQ;
                    req_d    = 1'b1;
                    timer_d  = '0;
                    head_d   = fifo_head;
                    dispatch = 1'b1;
                end
            end
            SCH_REQ: begin
                timer_d = timer_q + TMR_W'(1);
                // A done on the expiry cycle counts as a normal completion.
                if (probe_req_done) begin
                    state_d = SCH_POP;
                    req_d   = 1'b0;
                end else if (tmo_hit) begin
                    state_d = SCH_POP;
                    req_d   = 1'b0;
                    tmo     = 1'b1;
                end else if (probe_req_ack) begin
                    state_d = SCH_BUSY;
                    req_d   = 1'b0;
                end
            end
            SCH_BUSY: begin
                timer_d = timer_q + TMR_W'(1);
                if (probe_req_done) begin
                    state_d = SCH_POP;
                end else if (tmo_hit) begin
                    state_d = SCH_POP;
                    tmo     = 1'b1;
                end
            end
            SCH_POP: begin
                fifo_pop = 1'b1;
                state_d  = SCH_IDLE;
            end
            default: begin
                state_d = SCH_IDLE;
                req_d   = 1'b0;
            end
        endcase
        err_d = tmo ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SCH_IDLE;
            req_q   <= 1'b0;
            timer_q <= '0;
            head_q  <= '0;
            err_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            timer_q <= timer_d;
            head_q  <= head_d;
            err_q   <= err_d;
            init_q  <= 1'b1;
        end
    end

    assign probe_req   = req_q;
    assign prb_size    = head_q.size;
    assign prb_source  = head_q.source;
    assign prb_address = head_q.address;
    assign prb_busy    = (state_q == SCH_REQ) || (state_q == SCH_BUSY);
    assign prb_timeout = tmo;
    assign prb_err     = err_q;

`ifdef PRB_SCHED_STATS_EN
    logic [CNT_W-1:0] disp_cnt_q, disp_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        disp_cnt_d = disp_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        if (dispatch && !(&disp_cnt_q)) disp_cnt_d = disp_cnt_q + CNT_W'(1);
        if (tmo && !(&tmo_cnt_q))       tmo_cnt_d  = tmo_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            disp_cnt_q <= disp_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign prb_disp_cnt = disp_cnt_q;
    assign prb_tmo_cnt  = tmo_cnt_q;
`else
    logic unused_dispatch;
    assign unused_dispatch = dispatch;
`endif

endmodule
